branch_predictor_bht: RTL

- Parametrised branch target buffer with per-entry saturating counters. It replaces the single-bit hit/prediction branch unit.
- Looks up the fetch PC in IF and returns hit, predicted direction and target.
- Accepts branch resolution from EX and computes PC-mux select, redirect PC and flush.
- Updates its direct-mapped table on the clock edge.

---
 rtl/branch_predictor_bht.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// IF looks up the fetch PC combinationally; EX resolution drives the PC mux,
// the redirect PC and flush, and updates the table on the clock edge.
// Optional feature macro: BPU_STATS_EN adds saturating resolved-branch and
// mispredict counters; without it the statistics ports are tied to zero.
module branch_predictor_bht #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  input  logic            ex_hit,
  input  logic            ex_pred,
  input  logic [PC_W-1:0] ex_pred_target,
  input  logic            stall,
  output logic [1:0]      mux_pc,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int unsigned Depth = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntWeak = CNT_W'(1) << (CNT_W - 1);

  logic [Depth-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [Depth];
  logic [PC_W-1:0]  tgt_q [Depth];
  logic [CNT_W-1:0] cnt_q [Depth];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             ex_tbl_hit;
  logic             upd_en;
  logic             wr_en;
  logic [TAG_W-1:0] wr_tag;
  logic [PC_W-1:0]  wr_tgt;
  logic [CNT_W-1:0] wr_cnt;
  logic             mispredict;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];

  // ex_hit carried from IF is not needed: hit is recomputed from table state.
  logic unused_inputs;
  assign unused_inputs = ^{ex_hit, if_pc[1:0], if_pc[PC_W-1:IDX_W+TAG_W+2],
                           ex_pc[1:0], ex_pc[PC_W-1:IDX_W+TAG_W+2]};

  // IF lookup from registered state; no bypass of a same-cycle update.
  always_comb begin
    pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = pred_hit && cnt_q[if_idx][CNT_W-1];
    pred_target = pred_hit ? tgt_q[if_idx] : '0;
  end

  assign upd_en     = ex_valid && !stall;
  assign ex_tbl_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // Next value for the entry addressed by ex_pc.
  always_comb begin
    wr_en  = 1'b0;
    wr_tag = tag_q[ex_idx];
    wr_tgt = tgt_q[ex_idx];
    wr_cnt = cnt_q[ex_idx];
    if (upd_en) begin
      if (ex_tbl_hit) begin
        wr_en = 1'b1;
        if (ex_taken) begin
          wr_tgt = ex_target;
          if (cnt_q[ex_idx] != CntMax) wr_cnt = cnt_q[ex_idx] + CNT_W'(1);
        end else if (cnt_q[ex_idx] != '0) begin
          wr_cnt = cnt_q[ex_idx] - CNT_W'(1);
        end
      end else if (ex_taken) begin
        // Allocate, replacing whatever alias lived in this slot.
        wr_en  = 1'b1;
        wr_tag = ex_tag;
        wr_tgt = ex_target;
        wr_cnt = CntWeak;
      end
    end
  end

  // Table state; reset clears every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else if (wr_en) begin
      valid_q[ex_idx] <= 1'b1;
      tag_q[ex_idx]   <= wr_tag;
      tgt_q[ex_idx]   <= wr_tgt;
      cnt_q[ex_idx]   <= wr_cnt;
    end
  end

  assign mispredict = ex_valid &&
                      ((ex_pred != ex_taken) ||
                       (ex_pred && ex_taken && (ex_pred_target != ex_target)));

  // PC mux select, redirect and flush; EX corrections take priority over IF.
  always_comb begin
    mux_pc = 2'd0;
    flush  = 1'b0;
    if (mispredict) begin
      flush  = 1'b1;
      mux_pc = ex_taken ? 2'd3 : 2'd2;
    end else if (pred_taken) begin
      mux_pc = 2'd1;
    end
    case (mux_pc)
      2'd0:    redirect_pc = if_pc + PC_W'(4);
      2'd1:    redirect_pc = pred_target;
      2'd2:    redirect_pc = ex_pc + PC_W'(4);
      default: redirect_pc = ex_target;
    endcase
  end

`ifdef BPU_STATS_EN
  logic [31:0] br_q, mis_q;

  // Saturating statistics counters, frozen by stall like the table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_q  <= '0;
      mis_q <= '0;
    end else if (upd_en) begin
      if (br_q != 32'hFFFF_FFFF) br_q <= br_q + 32'd1;
      if (mispredict && (mis_q != 32'hFFFF_FFFF)) mis_q <= mis_q + 32'd1;
    end
  end

  assign stat_branches    = br_q;
  assign stat_mispredicts = mis_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule
